// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    StHold,
    StWaitLock,
    StStable,
    StRun,
    StFail
  } state_e;

  localparam int unsigned RetryW = 8;

  // Wide enough to count to the largest phase length, plus a spare bit.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; resets to zero.
module sync_2ff #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives PLL reset, qualifies lock, and releases a clean core reset with bounded retries.
// Define PLL_SEQ_LOSS_FILTER_EN to require LOSS_FILTER consecutive low lock cycles in RUN.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT  = 4096,
  parameter int unsigned STABLE_CYCLES = 256,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned LOSS_FILTER   = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pll_lock,
  input  logic              restart,
  output logic              pll_resetb,
  output logic              sys_rst_n,
  output logic              fail,
  output logic [RetryW-1:0] retry_cnt,
  output logic [RetryW-1:0] loss_cnt
);

  localparam int unsigned CntW = cnt_width(HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CntW-1:0]   HoldLast    = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0]   TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0]   StableLast  = CntW'(STABLE_CYCLES - 1);
  localparam logic [RetryW-1:0] MaxRetry    = RetryW'(MAX_RETRIES);

  if (HOLD_CYCLES < 1 || LOCK_TIMEOUT < 1 || STABLE_CYCLES < 1 || LOSS_FILTER < 1 ||
      MAX_RETRIES > 255) begin : g_bad_param
    $error("pll_reset_sequencer: parameter out of range");
  end

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [RetryW-1:0] retry_q;
  logic [RetryW-1:0] loss_q;
  logic              resetb_q;
  logic              sysrst_q;
  logic              fail_q;
  logic              lock_s;
  logic              loss_hit;

  sync_2ff #(
    .Width(1)
  ) u_lock_sync (
    .clk_i (clk),
    .rst_ni(resetn),
    .d_i   (pll_lock),
    .q_o   (lock_s)
  );

`ifdef PLL_SEQ_LOSS_FILTER_EN
  localparam int unsigned FiltW = $clog2(LOSS_FILTER) + 1;
  localparam logic [FiltW-1:0] FiltLast = FiltW'(LOSS_FILTER - 1);

  logic [FiltW-1:0] filt_q;

  assign loss_hit = !lock_s && (filt_q == FiltLast);

  // Counts consecutive low lock cycles seen in RUN; any high cycle clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      filt_q <= '0;
    end else if (restart || state_q != StRun || lock_s || loss_hit) begin
      filt_q <= '0;
    end else begin
      filt_q <= filt_q + FiltW'(1);
    end
  end
`else
  assign loss_hit = !lock_s;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StHold;
      cnt_q    <= '0;
      retry_q  <= '0;
      loss_q   <= '0;
      resetb_q <= 1'b0;
      sysrst_q <= 1'b0;
      fail_q   <= 1'b0;
    end else if (restart) begin
      state_q  <= StHold;
      cnt_q    <= '0;
      retry_q  <= '0;
      resetb_q <= 1'b0;
      sysrst_q <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StHold: begin
          if (cnt_q == HoldLast) begin
            state_q  <= StWaitLock;
            cnt_q    <= '0;
            resetb_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StWaitLock: begin
          if (lock_s) begin
            state_q <= StStable;
            cnt_q   <= '0;
          end else if (cnt_q == TimeoutLast) begin
            cnt_q    <= '0;
            resetb_q <= 1'b0;
            if (retry_q == MaxRetry) begin
              state_q <= StFail;
              fail_q  <= 1'b1;
            end else begin
              state_q <= StHold;
              retry_q <= retry_q + RetryW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStable: begin
          // A glitch here is not a retry: fall back and restart the lock timeout.
          if (!lock_s) begin
            state_q <= StWaitLock;
            cnt_q   <= '0;
          end else if (cnt_q == StableLast) begin
            state_q  <= StRun;
            cnt_q    <= '0;
            sysrst_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StRun: begin
          if (loss_hit) begin
            state_q  <= StHold;
            cnt_q    <= '0;
            retry_q  <= '0;
            resetb_q <= 1'b0;
            sysrst_q <= 1'b0;
            if (loss_q != '1) loss_q <= loss_q + RetryW'(1);
          end
        end
        StFail: begin
          cnt_q <= '0;
        end
        default: begin
          state_q  <= StHold;
          cnt_q    <= '0;
          resetb_q <= 1'b0;
          sysrst_q <= 1'b0;
        end
      endcase
    end
  end

  assign pll_resetb = resetb_q;
  assign sys_rst_n  = sysrst_q;
  assign fail       = fail_q;
  assign retry_cnt  = retry_q;
  assign loss_cnt   = loss_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: vector table plus hand-built corner sequences.
module tb_pll_reset_sequencer;

  logic       clk;
  logic       resetn;
  logic       pll_lock;
  logic       restart;
  logic       pll_resetb;
  logic       sys_rst_n;
  logic       fail;
  logic [7:0] retry_cnt;
  logic [7:0] loss_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        lock;
    logic        rst;
    int unsigned n;
    logic        rb;
    logic        sr;
    logic        f;
    logic [7:0]  rc;
    logic [7:0]  lc;
  } vec_t;

  vec_t tbl[$];

  pll_reset_sequencer #(
    .HOLD_CYCLES  (4),
    .LOCK_TIMEOUT (16),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (2),
    .LOSS_FILTER  (4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .pll_lock  (pll_lock),
    .restart   (restart),
    .pll_resetb(pll_resetb),
    .sys_rst_n (sys_rst_n),
    .fail      (fail),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic lock, input logic rst, input int unsigned n, input logic rb,
                     input logic sr, input logic f, input logic [7:0] rc, input logic [7:0] lc);
    vec_t v;
    v.lock = lock; v.rst = rst; v.n = n;
    v.rb = rb; v.sr = sr; v.f = f; v.rc = rc; v.lc = lc;
    tbl.push_back(v);
  endtask

  // Drive inputs just after an edge; restart is held for the first edge only.
  task automatic run(input logic lock, input logic rst, input int unsigned n);
    pll_lock = lock;
    restart  = rst;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      restart = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic rb, input logic sr, input logic f,
                       input logic [7:0] rc, input logic [7:0] lc);
    total++;
    if ({pll_resetb, sys_rst_n, fail, retry_cnt, loss_cnt} !== {rb, sr, f, rc, lc}) begin
      bad++;
      $display("FAIL %s: got resetb=%b sysrst=%b fail=%b retry=%0d loss=%0d, want %b %b %b %0d %0d",
               name, pll_resetb, sys_rst_n, fail, retry_cnt, loss_cnt, rb, sr, f, rc, lc);
    end
  endtask

  initial begin
    resetn   = 1'b0;
    pll_lock = 1'b0;
    restart  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_values", 0, 0, 0, 0, 0);
    resetn = 1'b1;

    // Nominal lock, then restart and a PLL that never locks.
    add(0, 0, 3,  0, 0, 0, 0, 0);
    add(0, 0, 1,  1, 0, 0, 0, 0);
    add(0, 0, 2,  1, 0, 0, 0, 0);
    add(1, 0, 10, 1, 0, 0, 0, 0);
    add(1, 0, 1,  1, 1, 0, 0, 0);
    add(0, 1, 1,  0, 0, 0, 0, 0);
    add(0, 0, 3,  0, 0, 0, 0, 0);
    add(0, 0, 1,  1, 0, 0, 0, 0);
    add(0, 0, 15, 1, 0, 0, 0, 0);
    add(0, 0, 1,  0, 0, 0, 1, 0);
    add(0, 0, 3,  0, 0, 0, 1, 0);
    add(0, 0, 1,  1, 0, 0, 1, 0);
    add(0, 0, 15, 1, 0, 0, 1, 0);
    add(0, 0, 1,  0, 0, 0, 2, 0);
    add(0, 0, 3,  0, 0, 0, 2, 0);
    add(0, 0, 1,  1, 0, 0, 2, 0);
    add(0, 0, 15, 1, 0, 0, 2, 0);
    add(0, 0, 1,  0, 0, 1, 2, 0);
    add(0, 0, 5,  0, 0, 1, 2, 0);
    add(0, 1, 1,  0, 0, 0, 0, 0);
    add(0, 0, 3,  0, 0, 0, 0, 0);
    add(0, 0, 1,  1, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      run(tbl[i].lock, tbl[i].rst, tbl[i].n);
      check($sformatf("vec%0d", i), tbl[i].rb, tbl[i].sr, tbl[i].f, tbl[i].rc, tbl[i].lc);
    end

    // Lock glitch during STABLE: no retry, stability count restarts.
    run(0, 1, 1);
    run(0, 0, 4);
    check("glitch_wait", 1, 0, 0, 0, 0);
    run(1, 0, 5);
    run(0, 0, 1);
    run(1, 0, 9);
    check("glitch_mid", 1, 0, 0, 0, 0);
    run(1, 0, 1);
    check("glitch_pre_run", 1, 0, 0, 0, 0);
    run(1, 0, 1);
    check("glitch_run", 1, 1, 0, 0, 0);

    // Lock loss in RUN.
    run(1, 0, 2);
`ifdef PLL_SEQ_LOSS_FILTER_EN
    run(0, 0, 3);
    run(1, 0, 4);
    check("filt_ignore", 1, 1, 0, 0, 0);
    run(0, 0, 4);
    run(1, 0, 1);
    check("filt_lag", 1, 1, 0, 0, 0);
    run(1, 0, 1);
    check("filt_fall", 0, 0, 0, 0, 1);
`else
    run(0, 0, 1);
    run(1, 0, 1);
    check("loss_lag", 1, 1, 0, 0, 0);
    run(1, 0, 1);
    check("loss_fall", 0, 0, 0, 0, 1);
`endif
    run(1, 0, 4);
    check("reseq_hold", 1, 0, 0, 0, 1);
    run(1, 0, 8);
    check("reseq_stable", 1, 0, 0, 0, 1);
    run(1, 0, 1);
    check("reseq_run", 1, 1, 0, 0, 1);

    // restart on the same edge as the WAIT_LOCK timeout.
    run(0, 1, 1);
    check("s5_restart", 0, 0, 0, 0, 1);
    run(0, 0, 4);
    check("s5_wait", 1, 0, 0, 0, 1);
    run(0, 0, 15);
    check("s5_pre_timeout", 1, 0, 0, 0, 1);
    run(0, 1, 1);
    check("s5_restart_wins", 0, 0, 0, 0, 1);
    run(0, 0, 3);
    check("s5_hold", 0, 0, 0, 0, 1);
    run(0, 0, 1);
    check("s5_hold_done", 1, 0, 0, 0, 1);

    // Asynchronous reset in RUN, then in FAIL.
    run(1, 1, 1);
    run(1, 0, 12);
    check("s6_pre_run", 1, 0, 0, 0, 1);
    run(1, 0, 1);
    check("s6_run", 1, 1, 0, 0, 1);
    #3 resetn = 1'b0;
    #1 check("s6_async_run", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    run(0, 0, 59);
    check("s6_pre_fail", 1, 0, 0, 2, 0);
    run(0, 0, 1);
    check("s6_fail", 0, 0, 1, 2, 0);
    #3 resetn = 1'b0;
    #1 check("s6_async_fail", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
